// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin finder.
// Index helpers work for any requester count, including counts that are not a power of two.
package uart_arb_pkg;

  typedef enum logic {IDLE, OWN} arb_state_t;

  localparam int unsigned IDLE_TIMEOUT_DEFAULT = 1302;
  localparam int unsigned N_REQ_MAX            = 8;

  // Width of a grant index for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Widest grant index any arbiter built from this package can need.
  typedef logic [$clog2(N_REQ_MAX)-1:0] grant_idx_max_t;

  function automatic int unsigned rr_next(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first valid index after `last`, with wrap.
// Kept free of arbiter state so the loader arbiter can reuse it.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    last,
  output logic             found,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  // Scan farthest offset first so the nearest valid index wins the final write.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'(rr_next(32'(last), 32'(k), N_REQ));
      if (valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter; packets stay contiguous,
// ownership is bounded by a burst limit and an owner idle timeout.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from last_owner+1
// OWN   | owner's bytes flow into the output register until last/burst/timeout
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][7:0]      req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int unsigned IW = idx_width(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);

  typedef logic [IW-1:0] grant_idx_t;

  arb_state_t    state;
  grant_idx_t    owner;
  grant_idx_t    last_owner;
  grant_idx_t    pick_idx;
  logic          pick_found;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_next;
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_next;
  logic          owner_valid;
  logic          owner_last;
  logic [7:0]    owner_data;
  logic          can_take;
  logic          accept;
  logic          release_now;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .valid (req_valid),
    .last  (last_owner),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign owner_data  = req_data[owner];

  // The output register can take a byte when empty or draining this cycle.
  assign can_take = !tx_valid || tx_ready;
  assign accept   = (state == OWN) && owner_valid && can_take;

  assign burst_next = (burst_cnt == BW'(MAX_BURST)) ? burst_cnt : burst_cnt + BW'(1);
  assign idle_next  = (idle_cnt == TW'(IDLE_TIMEOUT)) ? idle_cnt : idle_cnt + TW'(1);

  // Idle counting only advances while the owner has nothing to offer.
  assign release_now = (state == OWN) &&
                       ((accept && (owner_last || (burst_next == BW'(MAX_BURST)))) ||
                        (!owner_valid && (idle_next == TW'(IDLE_TIMEOUT))));

  always_comb begin
    req_ready = '0;
    if ((state == OWN) && can_take) begin
      req_ready[owner] = 1'b1;
    end
  end

  assign grant_id = owner;
  assign busy     = (state == OWN) || tx_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= grant_idx_t'(N_REQ - 1);
      burst_cnt  <= '0;
      idle_cnt   <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      if (accept) begin
        tx_data  <= owner_data;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            owner      <= pick_idx;
            last_owner <= pick_idx;
            burst_cnt  <= '0;
            idle_cnt   <= '0;
            state      <= OWN;
          end
        end
        OWN: begin
          if (accept) begin
            burst_cnt <= burst_next;
            idle_cnt  <= '0;
          end else if (!owner_valid) begin
            idle_cnt <= idle_next;
          end
          // A pending last byte may still sit in tx_data; the next grant does not wait for it.
          if (release_now) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle table, directed corner cases,
// and randomized packet streams against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int MB = 16;
  localparam int TO = 1302;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0][7:0] req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic             grant_id;
  logic             busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       trdy;
    logic [1:0] e_rr;
    logic       e_tv;
    logic [7:0] e_td;
    logic       e_gid;
    logic       e_busy;
  } vec_t;

  byte_t      src_q[2][$];
  bit         src_en[2];
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         cyc;
  int         first_acc[2];
  int         last_acc[2];
  bit         txr_rand;
  logic       txr_fixed;
  int         n_checks;
  int         n_fail;

  logic [1:0] s_rr;
  logic       s_tv;
  logic [7:0] s_td;
  int         s_idle;
  logic       p_tv;
  logic       p_trdy;
  logic [7:0] p_td;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_en[i] && src_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i]  = src_q[i][0].d;
        req_last[i]  = src_q[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'h00;
        req_last[i]  = 1'b0;
      end
    end
    tx_ready = txr_rand ? ($urandom_range(0, 99) < 70) : txr_fixed;
  endtask

  task automatic step();
    bit acc[2];
    @(negedge clk);
    s_rr   = req_ready;
    s_tv   = tx_valid;
    s_td   = tx_data;
    s_idle = int'(dut.idle_cnt);
    chk("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
    if (p_tv && !p_trdy) begin
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_data", 32'(tx_data), 32'(p_td));
    end
    for (int i = 0; i < N; i++) begin
      acc[i] = req_valid[i] && req_ready[i];
      if (acc[i]) begin
        if (first_acc[i] < 0) first_acc[i] = cyc;
        last_acc[i] = cyc;
      end
    end
    if (tx_valid && tx_ready) obs_q.push_back(tx_data);
    p_tv   = tx_valid;
    p_trdy = tx_ready;
    p_td   = tx_data;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    drive_inputs();
  endtask

  task automatic clear_state();
    src_q[0].delete();
    src_q[1].delete();
    obs_q.delete();
    exp_q.delete();
    src_en[0]    = 1'b1;
    src_en[1]    = 1'b1;
    txr_rand     = 1'b0;
    txr_fixed    = 1'b1;
    p_tv         = 1'b0;
    p_trdy       = 1'b1;
    p_td         = 8'h00;
    first_acc[0] = -1;
    first_acc[1] = -1;
    last_acc[0]  = -1;
    last_acc[1]  = -1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_state();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic push_byte(input int src, input logic [7:0] d, input logic l);
    byte_t b;
    b.d = d;
    b.l = l;
    src_q[src].push_back(b);
  endtask

  task automatic cmp_seq(input string nm);
    chk({nm, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", nm, i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
  endtask

  // Packet-level reference: every requester with bytes left is valid at each
  // handover, so the line order is round-robin over non-empty streams, each
  // turn ending at a last byte, after MB bytes, or when that stream runs dry.
  task automatic model_expect();
    byte_t mq[2][$];
    byte_t b;
    int    lo;
    int    own;
    int    n;
    bit    stop;
    mq[0] = src_q[0];
    mq[1] = src_q[1];
    exp_q.delete();
    lo = N - 1;
    while (mq[0].size() + mq[1].size() > 0) begin
      own = -1;
      for (int k = 1; k <= N; k++) begin
        if (own < 0 && mq[(lo + k) % N].size() > 0) own = (lo + k) % N;
      end
      n    = 0;
      stop = 1'b0;
      while (!stop) begin
        b = mq[own].pop_front();
        exp_q.push_back(b.d);
        n++;
        stop = b.l || (n == MB) || (mq[own].size() == 0);
      end
      lo = own;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    reset_n   = 1'b0;

    tbl[0] = '{v0:1'b0, d0:8'h00, l0:1'b0, trdy:1'b1, e_rr:2'b00, e_tv:1'b0, e_td:8'h00, e_gid:1'b0, e_busy:1'b0};
    tbl[1] = '{v0:1'b1, d0:8'h41, l0:1'b0, trdy:1'b1, e_rr:2'b00, e_tv:1'b0, e_td:8'h00, e_gid:1'b0, e_busy:1'b0};
    tbl[2] = '{v0:1'b1, d0:8'h41, l0:1'b0, trdy:1'b1, e_rr:2'b01, e_tv:1'b0, e_td:8'h00, e_gid:1'b0, e_busy:1'b1};
    tbl[3] = '{v0:1'b1, d0:8'h42, l0:1'b0, trdy:1'b1, e_rr:2'b01, e_tv:1'b1, e_td:8'h41, e_gid:1'b0, e_busy:1'b1};
    tbl[4] = '{v0:1'b1, d0:8'h43, l0:1'b1, trdy:1'b1, e_rr:2'b01, e_tv:1'b1, e_td:8'h42, e_gid:1'b0, e_busy:1'b1};
    tbl[5] = '{v0:1'b0, d0:8'h00, l0:1'b0, trdy:1'b1, e_rr:2'b00, e_tv:1'b1, e_td:8'h43, e_gid:1'b0, e_busy:1'b1};
    tbl[6] = '{v0:1'b0, d0:8'h00, l0:1'b0, trdy:1'b1, e_rr:2'b00, e_tv:1'b0, e_td:8'h43, e_gid:1'b0, e_busy:1'b0};

    // Single requester, three-byte packet, cycle by cycle.
    apply_reset();
    for (int r = 0; r < 7; r++) begin
      req_valid   = {1'b0, tbl[r].v0};
      req_data[0] = tbl[r].d0;
      req_data[1] = 8'h00;
      req_last    = {1'b0, tbl[r].l0};
      tx_ready    = tbl[r].trdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_req_ready", r), 32'(req_ready), 32'(tbl[r].e_rr));
      chk($sformatf("tbl%0d_tx_valid", r), 32'(tx_valid), 32'(tbl[r].e_tv));
      chk($sformatf("tbl%0d_tx_data", r), 32'(tx_data), 32'(tbl[r].e_td));
      chk($sformatf("tbl%0d_grant_id", r), 32'(grant_id), 32'(tbl[r].e_gid));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
      @(posedge clk);
      #1;
    end

    // Simultaneous two-byte packets: req0 first, one IDLE cycle, then req1.
    apply_reset();
    push_byte(0, 8'h21, 1'b0);
    push_byte(0, 8'h22, 1'b1);
    push_byte(1, 8'h31, 1'b0);
    push_byte(1, 8'h32, 1'b1);
    drive_inputs();
    for (int k = 0; k < 40 && obs_q.size() < 4; k++) step();
    exp_q = '{8'h21, 8'h22, 8'h31, 8'h32};
    cmp_seq("t2");
    chk("t2_handover_gap", 32'(first_acc[1] - last_acc[0]), 32'd2);

    // Burst limit: req1 streams 20 bytes, req0 arrives after the grant.
    apply_reset();
    src_en[0] = 1'b0;
    for (int i = 0; i < 20; i++) push_byte(1, 8'(8'h80 + i), i == 19);
    push_byte(0, 8'h10, 1'b0);
    push_byte(0, 8'h11, 1'b1);
    drive_inputs();
    for (int k = 0; k < 10 && src_q[1].size() == 20; k++) step();
    src_en[0] = 1'b1;
    drive_inputs();
    for (int k = 0; k < 300 && obs_q.size() < 22; k++) step();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h80 + i));
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'(8'h80 + i));
    cmp_seq("t3");

    // Idle timeout: req0 stalls mid-packet while req1 waits.
    apply_reset();
    push_byte(0, 8'h55, 1'b0);
    push_byte(1, 8'h66, 1'b1);
    drive_inputs();
    for (int k = 0; k < 10 && last_acc[0] < 0; k++) step();
    for (int k = 0; k < TO + 50 && first_acc[1] < 0; k++) step();
    chk("t4_req1_granted", 32'(first_acc[1] >= 0), 32'd1);
    chk("t4_release_delay", 32'(first_acc[1] - last_acc[0]), 32'(TO + 2));
    for (int k = 0; k < 5 && obs_q.size() < 2; k++) step();
    exp_q = '{8'h55, 8'h66};
    cmp_seq("t4");

    // Backpressure for ten cycles mid-packet.
    apply_reset();
    for (int i = 0; i < 6; i++) push_byte(0, 8'(8'h70 + i), i == 5);
    drive_inputs();
    for (int k = 0; k < 10 && src_q[0].size() > 4; k++) step();
    txr_fixed = 1'b0;
    tx_ready  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t5_req_ready", 32'(s_rr), 32'd0);
      chk("t5_tx_valid", 32'(s_tv), 32'd1);
      chk("t5_tx_data", 32'(s_td), 32'h71);
      chk("t5_idle_cnt", 32'(s_idle), 32'd0);
    end
    txr_fixed = 1'b1;
    tx_ready  = 1'b1;
    for (int k = 0; k < 30 && obs_q.size() < 6; k++) step();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h70 + i));
    cmp_seq("t5");

    // Asynchronous reset while a byte is pending in OWN.
    apply_reset();
    for (int i = 0; i < 4; i++) push_byte(0, 8'(8'h90 + i), i == 3);
    drive_inputs();
    for (int k = 0; k < 10 && src_q[0].size() > 2; k++) step();
    chk("t6_pending_before_reset", 32'(tx_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_tx_data", 32'(tx_data), 32'h00);
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_grant_id", 32'(grant_id), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_hold_busy", 32'(busy), 32'd0);
    chk("t6_rst_hold_req_ready", 32'(req_ready), 32'd0);
    clear_state();
    push_byte(0, 8'hA0, 1'b1);
    push_byte(1, 8'hB0, 1'b1);
    drive_inputs();
    reset_n = 1'b1;
    for (int k = 0; k < 20 && obs_q.size() < 2; k++) step();
    exp_q = '{8'hA0, 8'hB0};
    cmp_seq("t6");

    // Randomized packet streams with random serializer backpressure.
    for (int round = 0; round < 3; round++) begin
      apply_reset();
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(2, 5);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 24);
          for (int j = 0; j < len; j++) push_byte(i, 8'($urandom), j == len - 1);
        end
      end
      model_expect();
      txr_rand = 1'b1;
      drive_inputs();
      for (int k = 0; k < 4000 && obs_q.size() < exp_q.size(); k++) step();
      cmp_seq($sformatf("rand%0d", round));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the chip's single UART transmitter between `N_REQ` byte producers (core output stream, loader echo, debug dump). It sits between the requesters and the UART TX serializer inside `Chip`. Ownership is granted round-robin. A packet (`req_last`) is kept contiguous on the line, and hogging is bounded by a burst limit and an idle timeout. The output is a registered valid/ready byte stream.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `MAX_BURST`, 16: maximum bytes accepted per grant before forced release.
- `IDLE_TIMEOUT`, 1302: owner idle cycles (no `req_valid`) before forced release; equals one UART bit time at 150 MHz / 115200 baud.
- `clk` in 1: system clock (150 MHz).
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in [N_REQ]: requester i has a byte.
- `req_data` in [N_REQ][8]: byte from requester i.
- `req_last` in [N_REQ]: byte is the last of a packet.
- `req_ready` out [N_REQ]: byte from requester i accepted this cycle when `req_valid` is also high.
- `tx_valid` out 1: byte to serializer valid.
- `tx_data` out 8: byte to serializer.
- `tx_ready` in 1: serializer accepts the byte.
- `grant_id` out $clog2(N_REQ): current or last owner index.
- `busy` out 1: `state==OWN || tx_valid`.

## Operation
- States: IDLE and OWN.
- IDLE:
  - If any `req_valid` is high, pick the first valid index searching from `last_owner+1` mod N_REQ upward with wrap.
  - Set `owner`, `last_owner` and `grant_id` to that index; clear `burst_cnt` and `idle_cnt`; go to OWN.
  - No `req_valid` high: stay in IDLE.
- OWN:
  - `req_ready[owner] = (!tx_valid || tx_ready)`; all other `req_ready` bits are 0. `req_ready` is 0 for everyone in IDLE.
  - Accept = `req_valid[owner] && req_ready[owner]`.
  - On accept: `tx_data <= req_data[owner]`, `tx_valid <= 1`, `burst_cnt++`, `idle_cnt <= 0`.
  - Without accept and `!req_valid[owner]`: `idle_cnt++`. When `req_valid[owner]` is high but blocked by backpressure, `idle_cnt` holds.
- Output register: `tx_valid` clears on `tx_ready` when there is no new accept that cycle. Accept and drain in the same cycle keeps `tx_valid=1` with the new data.
- Release (OWN→IDLE) at the end of the cycle when any of these holds:
  - accept with `req_last[owner]=1`;
  - accept that makes `burst_cnt==MAX_BURST`;
  - `idle_cnt` reaching `IDLE_TIMEOUT`.
- Release does not wait for `tx_valid` to drain. The next grant may be issued while the last byte is still pending.
- Width rules:
  - `burst_cnt` is $clog2(MAX_BURST+1) bits and `idle_cnt` is $clog2(IDLE_TIMEOUT+1) bits.
  - Both saturate; neither wraps.
  - Index arithmetic is mod N_REQ, including non-power-of-2 N_REQ.
- Deasserting `req_valid` mid-packet does not cost ownership until the timeout fires.
- A requester never sees `req_ready` unless it is the owner.

## Timing
- Reset values:
  - `state=IDLE`, `tx_valid=0`, `tx_data=8'h00`, `req_ready=0`, `grant_id=0`, `busy=0`, `burst_cnt=0`, `idle_cnt=0`.
  - `last_owner=N_REQ-1`, so requester 0 wins first.
- Latency from IDLE:
  - `req_valid` high in cycle 0 → OWN and `req_ready` high in cycle 1 → `tx_valid` high in cycle 2.
- Throughput: with `tx_ready` held high, one byte per cycle inside a grant.
- Handover cost: one IDLE cycle between grants.
- Simultaneous requests in IDLE: the round-robin pointer decides; there is no fixed priority beyond the reset value.
- Release at accept: the byte accepted in the release cycle is still emitted.
- Reset asserted mid-operation: immediate asynchronous clear to the reset values. Any pending `tx_data` is dropped, and requesters must restart their packets.

## Structure
- Package `uart_arb_pkg`:
  - `typedef enum logic {IDLE, OWN} arb_state_t`;
  - grant index type parameterised by N_REQ;
  - localparam for the IDLE_TIMEOUT default (1302).
- Sub-module `rr_pick`: combinational round-robin finder with inputs `valid[N_REQ]` and `last`, and outputs `found` and `idx`. It is reusable for the loader arbiter.
- Top level: one FSM `always_ff` with async reset, plus counters and the output register.

## Test plan
- Reset, then only req0 sends 3 bytes 8'h41, 8'h42, 8'h43 (last on 8'h43) with `tx_ready=1` → `tx_valid` from cycle 2, bytes in order, return to IDLE, `grant_id=0`.
- req0 and req1 both send 2-byte packets simultaneously → req0 packet complete, one IDLE cycle, then req1 packet; no interleaving.
- req1 streams 20 bytes with no `req_last`, req0 is waiting, MAX_BURST=16 → 16 bytes from req1, then req0's bytes, then req1 resumes.
- req0 sends 1 byte without last, then drops valid while req1 waits → release exactly IDLE_TIMEOUT cycles after the last accept, req1 granted next.
- `tx_ready` held low for 10 cycles mid-packet → `req_ready=0`, `tx_data` stable, `idle_cnt` unchanged, no byte lost or duplicated.
- `reset_n` pulsed low while `tx_valid=1` in OWN → all outputs at reset values during the pulse; the next grant goes to req0.
